sha256_candidate_dispatcher: RTL and testbench
==============================================

Name: sha256_candidate_dispatcher

Overview:
- Sequences a brute-force password search across a pool of SHA-256 calculator cores.
- Enumerates candidate passwords over a contiguous ASCII range, in increasing length.
- Hands candidates out round-robin to idle calculators over a valid/ready handshake and tracks the candidate in flight per calculator.
- Collects match reports, picks the winning calculator and reports the password. Sits between the top-level start/finish control and the calculator array.

Parameters:
- n_calculators, 4, number of calculator cores served (1..16).
- max_characters, 4, maximum password length in bytes.
- char_lo, 8'h61, first character of the charset.
- char_hi, 8'h7A, last character of the charset (char_hi >= char_lo).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a search.
- abort  in  1  one-cycle pulse; cancels the search.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- finish  out  1  one-cycle pulse when the search ends by match or exhaustion.
- found  out  1  a match was found; held until the next accepted start.
- result_password  out  8*max_characters  matching candidate.
- result_length  out  $clog2(max_characters+1)  length of the match.
- winner_calculator  out  max(1,$clog2(n_calculators))  index of the matching core.
- cand_valid  out  n_calculators  one-hot offer to core i.
- cand_ready  in  n_calculators  core i idle and able to accept.
- cand_data  out  8*max_characters  shared candidate bus.
- cand_length  out  $clog2(max_characters+1)  shared length bus.
- calc_done  in  n_calculators  core i finished its candidate (one-cycle pulse).
- calc_match  in  n_calculators  qualifies calc_done: digest matched.

Behaviour:
- Reset values: all outputs 0; state IDLE; all slots free; round-robin pointer 0.
- Clocking: single clock aclk. aresetn is asynchronous and active-low; it returns the block to IDLE immediately, including mid-search.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start: clears found and result registers, loads the generator with length 1 and byte0 = char_lo, then enters RUN.
  - start while not in IDLE is ignored.
- Generator:
  - byte k occupies cand_data[8k+7:8k]; byte0 varies fastest; unused upper bytes are 0.
  - Increment: a byte at char_hi wraps to char_lo and carries to the next byte.
  - A carry out of byte (length-1) increments length and sets bytes 0..length-1 to char_lo.
  - The candidate with length = max_characters and all bytes at char_hi is the last one.
- RUN, offers:
  - At most one cand_valid bit is high at a time.
  - When no offer is pending, the lowest index i at or after the pointer (wrapping) with cand_ready[i]=1 and slot i free is offered on the next cycle.
  - cand_valid[i], cand_data and cand_length are registered and held stable until cand_valid[i] & cand_ready[i].
- RUN, transfer cycle: the candidate is copied into slot i, slot i is marked busy, the pointer becomes i+1 mod n_calculators, and the generator advances. Sustained throughput is one candidate per 2 cycles.
- Transfer of the last candidate: go to DRAIN.
- calc_done[i] handling:
  - With slot i busy: slot i is freed.
  - With calc_match[i] also set: a match.
  - calc_done on a free slot is ignored.
- Match (RUN or DRAIN):
  - Registers found=1, result_password/result_length from slot i and winner_calculator=i.
  - Simultaneous matches: the lowest index wins.
  - Any pending offer is withdrawn (cand_valid cleared even if not accepted).
  - Next cycle: finish=1, busy=0, state IDLE. Later done/match pulses are ignored.
- DRAIN: when all slots are free with no match, pulse finish with found=0 and go to IDLE.
- abort (RUN or DRAIN): clear cand_valid and all slots, go to IDLE. No finish pulse; found stays 0.
- abort and a match in the same cycle: abort wins.
- start and abort together in IDLE: start is ignored.
- Results are held after finish until the next accepted start.

Test Plan:
- Parameters used by every scenario: n_calculators=4, max_characters=4, char_lo=8'h61, char_hi=8'h63. Calculator model: cand_ready high when idle, calc_done 5 cycles after accept.
- Ordering: start, no match -> first candidates on cand_data are 0x61, 0x62, 0x63, 0x6161, 0x6162, with cand_length 1,1,1,2,2.
- Round robin: all cores ready -> grants go to cores 0,1,2,3,0 in order; cand_ready[2] held low -> order 0,1,3,0,1.
- Match: core model asserts calc_match for candidate 0x6362 -> found=1, result_password=0x6362, result_length=2, winner_calculator equals the core that received it, one finish pulse, no further cand_valid.
- Simultaneous match: cores 1 and 3 report match in the same cycle -> winner_calculator=1 with core 1's candidate.
- Exhaustion: no match -> exactly 120 transfers, last 0x63636363; finish only after all slots are freed; found=0.
- Abort/reset: abort after 10 transfers -> busy=0, no finish, cand_valid=0. aresetn low mid-run -> all outputs 0 asynchronously; a new start restarts at 0x61.

Source files
------------

// File: rtl/sha256_candidate_dispatcher.sv
`timescale 1ns/1ps
// sha256_candidate_dispatcher: enumerates candidate passwords and deals them round-robin to a pool of SHA-256 cores
module sha256_candidate_dispatcher #(
    parameter int n_calculators = 4,
    parameter int max_characters = 4,
    parameter logic [7:0] char_lo = 8'h61,
    parameter logic [7:0] char_hi = 8'h7A,
    localparam int dw = 8 * max_characters,
    localparam int lw = $clog2(max_characters + 1),
    localparam int ww = (n_calculators > 1) ? $clog2(n_calculators) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     finish,
    output logic                     found,
    output logic [dw-1:0]            result_password,
    output logic [lw-1:0]            result_length,
    output logic [ww-1:0]            winner_calculator,
    output logic [n_calculators-1:0] cand_valid,
    input  logic [n_calculators-1:0] cand_ready,
    output logic [dw-1:0]            cand_data,
    output logic [lw-1:0]            cand_length,
    input  logic [n_calculators-1:0] calc_done,
    input  logic [n_calculators-1:0] calc_match
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [n_calculators-1:0] slot_busy;
    logic [dw-1:0]           slot_data [n_calculators];
    logic [lw-1:0]           slot_len [n_calculators];
    logic [ww-1:0]           ptr;
    logic [ww-1:0]           offer_idx;

    logic [dw-1:0]           nxt_data;
    logic [lw-1:0]           nxt_len;
    logic                    carry;
    logic                    gen_last;
    logic                    sel_ok;
    logic [ww-1:0]           sel_idx;
    logic [ww-1:0]           j;
    logic                    hit;
    logic [ww-1:0]           hit_idx;
    logic [n_calculators-1:0] done_v;
    logic                    xfer;

    assign done_v   = calc_done & slot_busy;
    assign xfer     = |(cand_valid & cand_ready);
    assign gen_last = (cand_length == lw'(max_characters)) && (cand_data == {max_characters{char_hi}});

    // Next candidate: odometer increment over the live bytes, growing the length on overflow
    always_comb begin
        nxt_data = cand_data;
        nxt_len  = cand_length;
        carry    = 1'b1;
        for (int k = 0; k < max_characters; k++) begin
            if (carry && k < int'(cand_length)) begin
                carry = nxt_data[8*k +: 8] == char_hi;
                nxt_data[8*k +: 8] = carry ? char_lo : nxt_data[8*k +: 8] + 8'd1;
            end
        end
        if (carry) begin
            nxt_len = cand_length + lw'(1);
            for (int k = 0; k < max_characters; k++)
                if (k < int'(nxt_len)) nxt_data[8*k +: 8] = char_lo;
        end
    end

    // Offer target: first ready core with a free slot, searching from the pointer with wrap
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        j       = '0;
        for (int k = 0; k < n_calculators; k++) begin
            j = ww'((int'(ptr) + k) % n_calculators);
            if (!sel_ok && cand_ready[j] && !slot_busy[j]) begin
                sel_ok  = 1'b1;
                sel_idx = j;
            end
        end
    end

    // Match arbitration: lowest-index busy slot reporting done with a match
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = n_calculators - 1; k >= 0; k--) begin
            if (done_v[k] && calc_match[k]) begin
                hit     = 1'b1;
                hit_idx = ww'(k);
            end
        end
    end

    // Search control, offer handshake, slot bookkeeping and result capture
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= IDLE;
            busy              <= 1'b0;
            finish            <= 1'b0;
            found             <= 1'b0;
            result_password   <= '0;
            result_length     <= '0;
            winner_calculator <= '0;
            cand_valid        <= '0;
            cand_data         <= '0;
            cand_length       <= '0;
            slot_busy         <= '0;
            ptr               <= '0;
            offer_idx         <= '0;
            for (int k = 0; k < n_calculators; k++) begin
                slot_data[k] <= '0;
                slot_len[k]  <= '0;
            end
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state             <= RUN;
                        busy              <= 1'b1;
                        found             <= 1'b0;
                        result_password   <= '0;
                        result_length     <= '0;
                        winner_calculator <= '0;
                        cand_valid        <= '0;
                        cand_data         <= dw'(char_lo);
                        cand_length       <= lw'(1);
                        slot_busy         <= '0;
                        ptr               <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cand_valid <= '0;
                        slot_busy  <= '0;
                    end else if (hit) begin
                        state             <= IDLE;
                        busy              <= 1'b0;
                        finish            <= 1'b1;
                        found             <= 1'b1;
                        result_password   <= slot_data[hit_idx];
                        result_length     <= slot_len[hit_idx];
                        winner_calculator <= hit_idx;
                        cand_valid        <= '0;
                    end else if (state == DRAIN) begin
                        slot_busy <= slot_busy & ~done_v;
                        if (slot_busy == '0) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            finish <= 1'b1;
                        end
                    end else begin
                        slot_busy <= (slot_busy & ~done_v) | (xfer ? cand_valid : '0);
                        if (xfer) begin
                            slot_data[offer_idx] <= cand_data;
                            slot_len[offer_idx]  <= cand_length;
                            cand_valid           <= '0;
                            ptr                  <= (offer_idx == ww'(n_calculators - 1)) ? '0 : offer_idx + ww'(1);
                            cand_data            <= nxt_data;
                            cand_length          <= nxt_len;
                            if (gen_last) state <= DRAIN;
                        end else if (cand_valid == '0 && sel_ok) begin
                            cand_valid <= n_calculators'(1) << sel_idx;
                            offer_idx  <= sel_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_candidate_dispatcher.sv
`timescale 1ns/1ps
// tb_sha256_candidate_dispatcher: scenario bench with a calculator-pool model and transfer scoreboard
module tb_sha256_candidate_dispatcher;
    localparam int N = 4;
    localparam int M = 4;
    localparam logic [7:0] LO = 8'h61;
    localparam logic [7:0] HI = 8'h63;
    localparam int CS = 3;

    typedef struct packed {
        logic [1:0]  idx;
        logic [2:0]  len;
        logic [31:0] data;
    } xfer_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, finish, found;
    logic [31:0] result_password, cand_data;
    logic [2:0] result_length, cand_length;
    logic [1:0] winner_calculator;
    logic [N-1:0] cand_valid, cand_ready, calc_done, calc_match;

    logic [N-1:0] core_busy, done_r, match_r;
    logic [N-1:0] hold_low = '0;
    logic [N-1:0] force_done = '0;
    logic [N-1:0] force_match = '0;
    logic hold_done = 1'b0;
    logic match_en = 1'b0;
    logic [31:0] match_val = '0;
    int cnt [N];
    logic [31:0] core_data [N];

    xfer_t obs_q[$];
    xfer_t exp_q[$];
    int idx_q[$];
    int fin_cnt = 0;
    int valid_after = 0;
    logic post_fin = 1'b0;
    int checks = 0;
    int errors = 0;

    sha256_candidate_dispatcher #(
        .n_calculators(N), .max_characters(M), .char_lo(LO), .char_hi(HI)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .busy(busy), .finish(finish), .found(found),
        .result_password(result_password), .result_length(result_length),
        .winner_calculator(winner_calculator),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_data(cand_data), .cand_length(cand_length),
        .calc_done(calc_done), .calc_match(calc_match)
    );

    always #5 aclk = ~aclk;

    assign cand_ready = ~core_busy & ~hold_low;
    assign calc_done  = done_r | force_done;
    assign calc_match = match_r | force_match;

    // Calculator pool: ready when idle, done pulse five cycles after accepting
    always @(posedge aclk) begin
        for (int i = 0; i < N; i++) begin
            if (!aresetn) begin
                core_busy[i] <= 1'b0; done_r[i] <= 1'b0; match_r[i] <= 1'b0; cnt[i] <= 0;
            end else if (cand_valid[i] && cand_ready[i]) begin
                core_busy[i] <= 1'b1; cnt[i] <= 5; core_data[i] <= cand_data;
                done_r[i] <= 1'b0; match_r[i] <= 1'b0;
            end else if (core_busy[i] && cnt[i] > 1) begin
                cnt[i] <= cnt[i] - 1; done_r[i] <= 1'b0; match_r[i] <= 1'b0;
            end else if (core_busy[i] && !hold_done) begin
                core_busy[i] <= 1'b0; done_r[i] <= 1'b1;
                match_r[i] <= match_en && (core_data[i] == match_val);
            end else begin
                done_r[i] <= 1'b0; match_r[i] <= 1'b0;
            end
        end
    end

    // Transfer and finish monitor
    always @(negedge aclk) begin
        xfer_t x;
        x = '0;
        if (aresetn && (cand_valid & cand_ready) != '0) begin
            for (int i = 0; i < N; i++) if (cand_valid[i]) x.idx = 2'(i);
            x.len = cand_length;
            x.data = cand_data;
            obs_q.push_back(x);
        end
        if (finish) begin
            fin_cnt++;
            post_fin = 1'b1;
        end else if (post_fin && cand_valid != '0) valid_after++;
    end

    function automatic xfer_t gen(int n);
        xfer_t x;
        int l, p;
        x = '0; l = 1; p = CS;
        while (n >= p) begin n -= p; l++; p *= CS; end
        x.len = 3'(l);
        for (int k = 0; k < l; k++) begin
            x.data[8*k +: 8] = LO + 8'(n % CS);
            n /= CS;
        end
        return x;
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic pulse_start();
        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge aclk); abort = 1'b1;
        @(negedge aclk); abort = 1'b0;
    endtask

    task automatic wait_xfers(int n, string tag);
        int c = 0;
        while (obs_q.size() < n && c < 400) begin @(negedge aclk); c++; end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d transfers, need %0d", tag, obs_q.size(), n);
        end
    endtask

    task automatic wait_finish(int budget, string tag);
        int c = 0;
        while (finish !== 1'b1 && c < budget) begin @(negedge aclk); c++; end
        checks++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL %s finish timeout after %0d cycles", tag, c);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (core_busy != '0 && c < 200) begin @(negedge aclk); c++; end
        tick(3);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, finish, found, cand_valid} !== '0 || cand_data !== '0 || cand_length !== '0 ||
            result_password !== '0 || result_length !== '0 || winner_calculator !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b finish=%b found=%b valid=%b data=%h len=%0d pw=%h rl=%0d win=%0d, want all 0",
                     busy, finish, found, cand_valid, cand_data, cand_length, result_password, result_length, winner_calculator);
        end
        @(negedge aclk); aresetn = 1'b1;
        tick(2);
    endtask

    task automatic test_ordering();
        xfer_t o, e;
        obs_q.delete(); exp_q.delete();
        for (int n = 0; n < 5; n++) exp_q.push_back(gen(n));
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        wait_xfers(5, "ordering");
        for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.len !== e.len) begin
                errors++;
                $display("FAIL ordering[%0d]: got %h/%0d want %h/%0d", i, o.data, o.len, e.data, e.len);
            end
        end
        do_abort();
        wait_idle();
    endtask

    task automatic test_round_robin();
        int a0[5] = '{0, 1, 2, 3, 0};
        int a1[5] = '{0, 1, 3, 0, 1};
        xfer_t o;
        int e;
        for (int pass = 0; pass < 2; pass++) begin
            hold_low = (pass == 1) ? 4'b0100 : 4'b0000;
            obs_q.delete(); idx_q.delete();
            for (int i = 0; i < 5; i++) idx_q.push_back(pass == 1 ? a1[i] : a0[i]);
            pulse_start();
            wait_xfers(5, "round_robin");
            for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
                o = obs_q.pop_front(); e = idx_q.pop_front();
                checks++;
                if (int'(o.idx) != e) begin
                    errors++;
                    $display("FAIL round_robin pass%0d grant[%0d]: got core %0d want core %0d", pass, i, o.idx, e);
                end
            end
            do_abort();
            wait_idle();
        end
        hold_low = '0;
    endtask

    task automatic test_match();
        int want_win = -1;
        match_en = 1'b1; match_val = 32'h0000_6362;
        obs_q.delete(); fin_cnt = 0; valid_after = 0; post_fin = 1'b0;
        pulse_start();
        wait_finish(600, "match");
        foreach (obs_q[i]) if (obs_q[i].data == 32'h0000_6362) want_win = int'(obs_q[i].idx);
        checks++;
        if (found !== 1'b1 || result_password !== 32'h0000_6362 || result_length !== 3'd2) begin
            errors++;
            $display("FAIL match_result: found=%b pw=%h len=%0d want 1/00006362/2", found, result_password, result_length);
        end
        checks++;
        if (int'(winner_calculator) != want_win) begin
            errors++;
            $display("FAIL match_winner: got %0d want %0d", winner_calculator, want_win);
        end
        checks++;
        if (busy !== 1'b0 || cand_valid !== '0) begin
            errors++;
            $display("FAIL match_stop: busy=%b valid=%b want 0/0", busy, cand_valid);
        end
        tick(20);
        checks++;
        if (fin_cnt != 1 || valid_after != 0) begin
            errors++;
            $display("FAIL match_single_finish: finishes=%0d late_valid=%0d want 1/0", fin_cnt, valid_after);
        end
        checks++;
        if (found !== 1'b1 || result_password !== 32'h0000_6362) begin
            errors++;
            $display("FAIL match_hold: found=%b pw=%h want 1/00006362", found, result_password);
        end
        match_en = 1'b0;
        wait_idle();
    endtask

    task automatic test_simultaneous();
        xfer_t e;
        e = gen(1);
        hold_done = 1'b1;
        obs_q.delete();
        pulse_start();
        wait_xfers(4, "simultaneous");
        tick(2);
        @(negedge aclk); force_done = 4'b1010; force_match = 4'b1010;
        @(negedge aclk); force_done = '0; force_match = '0;
        wait_finish(10, "simultaneous");
        checks++;
        if (winner_calculator !== 2'd1 || result_password !== e.data || result_length !== e.len || found !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous: win=%0d pw=%h len=%0d found=%b want 1/%h/%0d/1",
                     winner_calculator, result_password, result_length, found, e.data, e.len);
        end
        hold_done = 1'b0;
        wait_idle();
    endtask

    task automatic test_exhaustion();
        xfer_t e;
        int bad = 0;
        obs_q.delete(); fin_cnt = 0;
        pulse_start();
        wait_finish(2000, "exhaustion");
        checks++;
        if (core_busy !== '0 || found !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_drain: cores_busy=%b found=%b want 0/0", core_busy, found);
        end
        checks++;
        if (obs_q.size() != 120) begin
            errors++;
            $display("FAIL exhaust_count: got %0d transfers want 120", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = gen(i);
            checks++;
            if (obs_q[i].data !== e.data || obs_q[i].len !== e.len) begin
                errors++;
                if (bad++ < 5) $display("FAIL exhaust_seq[%0d]: got %h/%0d want %h/%0d", i, obs_q[i].data, obs_q[i].len, e.data, e.len);
            end
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1].data !== 32'h6363_6363 || obs_q[obs_q.size()-1].len !== 3'd4) begin
            errors++;
            $display("FAIL exhaust_last: got %h want 63636363 len 4", obs_q.size() ? obs_q[obs_q.size()-1].data : 32'h0);
        end
        tick(5);
        checks++;
        if (fin_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_finish: finishes=%0d busy=%b want 1/0", fin_cnt, busy);
        end
        wait_idle();
    endtask

    task automatic test_abort();
        int n;
        obs_q.delete(); fin_cnt = 0;
        pulse_start();
        wait_xfers(10, "abort");
        do_abort();
        checks++;
        if (busy !== 1'b0 || cand_valid !== '0) begin
            errors++;
            $display("FAIL abort_stop: busy=%b valid=%b want 0/0", busy, cand_valid);
        end
        tick(20);
        checks++;
        if (fin_cnt != 0 || found !== 1'b0 || cand_valid !== '0) begin
            errors++;
            $display("FAIL abort_quiet: finishes=%0d found=%b valid=%b want 0/0/0", fin_cnt, found, cand_valid);
        end
        wait_idle();
        n = obs_q.size();
        @(negedge aclk); start = 1'b1; abort = 1'b1;
        @(negedge aclk); start = 1'b0; abort = 1'b0;
        tick(4);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != n) begin
            errors++;
            $display("FAIL start_with_abort: busy=%b new_transfers=%0d want 0/0", busy, obs_q.size() - n);
        end
    endtask

    task automatic test_async_reset();
        obs_q.delete();
        pulse_start();
        wait_xfers(3, "async_reset");
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({busy, finish, found, cand_valid} !== '0 || cand_data !== '0 || cand_length !== '0 ||
            result_password !== '0 || result_length !== '0 || winner_calculator !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b data=%h len=%0d want all 0", busy, cand_valid, cand_data, cand_length);
        end
        @(negedge aclk); aresetn = 1'b1;
        wait_idle();
        obs_q.delete();
        pulse_start();
        wait_xfers(1, "restart");
        checks++;
        if (obs_q.size() == 0 || obs_q[0].data !== 32'h61 || obs_q[0].len !== 3'd1 || obs_q[0].idx !== 2'd0) begin
            errors++;
            $display("FAIL restart_first: got %h len %0d", obs_q.size() ? obs_q[0].data : 32'h0, obs_q.size() ? obs_q[0].len : 3'd0);
        end
        do_abort();
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_round_robin();
        test_match();
        test_simultaneous();
        test_exhaustion();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
